// File: rtl/gate_truth_table_checker.sv
// Stimulus/checker for a 2-input gate bank: walks operands a,b through 00..11,
// samples the seven gate responses and accumulates mismatches against the truth table.
module gate_truth_table_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] resp,
  output logic       stim_a,
  output logic       stim_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [6:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  // Bit order matches resp: [0]AND [1]OR [2]NOT a [3]NAND [4]NOR [5]XOR [6]XNOR
  function automatic logic [6:0] expected_resp(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  endfunction

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d;
  logic [6:0] fail_q, fail_d;
  logic       pass_q, pass_d;
  logic [6:0] mism;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    mism    = resp ^ expected_resp(idx_q[0], idx_q[1]);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 3'd0;
          fail_d  = 7'd0;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          cnt_d   = CNT_LOAD;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == 4'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SAMPLE: begin
        fail_d = fail_q | mism;
        if (mism != 7'd0) err_d = err_q + 3'd1;
        if (idx_q == 2'd3) begin
          // Pass is resolved here so it is already valid while done is high.
          pass_d  = (err_d == 3'd0);
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = CNT_LOAD;
          state_d = DRIVE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      err_q   <= 3'd0;
      fail_q  <= 7'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign stim_a    = idx_q[0];
  assign stim_b    = idx_q[1];
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: a behavioural gate bank with injectable faults
// feeds the checker; expected run results go through a scoreboard queue.
module tb_gate_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst_n, start, start2;
  logic [6:0] resp, resp2;
  logic       stim_a, stim_b, busy, done, pass;
  logic       stim2_a, stim2_b, busy2, done2, pass2;
  logic [2:0] err_count, err_count2;
  logic [6:0] fail_vec, fail_vec2;
  int         fault = 0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  typedef struct {
    logic       pass;
    logic [2:0] err;
    logic [6:0] fv;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate bank: fault 1 = XOR stuck at 0, fault 2 = NOT output reports a.
  function automatic logic [6:0] bank(input logic a, input logic b, input int f);
    logic [6:0] r;
    r[0] = a & b;
    r[1] = a | b;
    r[2] = (f == 2) ? a : !a;
    r[3] = !(a && b);
    r[4] = !(a || b);
    r[5] = (f == 1) ? 1'b0 : (a != b);
    r[6] = (a == b);
    return r;
  endfunction

  always_comb resp  = bank(stim_a, stim_b, fault);
  always_comb resp2 = bank(stim2_a, stim2_b, 0);

  gate_truth_table_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .resp(resp),
    .stim_a(stim_a), .stim_b(stim_b), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
  );

  gate_truth_table_checker #(.SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .resp(resp2),
    .stim_a(stim2_a), .stim_b(stim2_b), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err_count2), .fail_vec(fail_vec2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run on dut (SETTLE_CYCLES=2). repulse_at >= 0 re-asserts start at that
  // cycle offset; start is also re-pulsed in the done cycle and must be ignored.
  task automatic run(input string tag, input int f, input logic [2:0] err_exp,
                     input logic [6:0] fv_exp, input int repulse_at);
    exp_t e;
    int   t0, got, ndone;
    fault = f;
    e.pass = (err_exp == 3'd0);
    e.err  = err_exp;
    e.fv   = fv_exp;
    sb.push_back(e);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t0 = cyc;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    got = -1;
    for (int i = 0; i < 40 && got < 0; i++) begin
      if (done) got = cyc;
      else begin
        start = (cyc - t0 == repulse_at);
        @(negedge clk);
        start = 1'b0;
      end
    end
    e = sb.pop_front();
    if (got < 0) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      // done sampled at edge t0+1+4*(SETTLE_CYCLES+1) is seen here after edge t0+12
      check({tag, "_latency"}, 32'(got - t0), 32'd12);
      check({tag, "_pass"}, 32'(pass), 32'(e.pass));
      check({tag, "_err"}, 32'(err_count), 32'(e.err));
      check({tag, "_fail_vec"}, 32'(fail_vec), 32'(e.fv));
      check({tag, "_busy_done"}, 32'(busy), 32'd1);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      check({tag, "_start_at_done_ignored"}, 32'(busy), 32'd0);
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (done) ndone++;
      end
      check({tag, "_no_extra_done"}, 32'(ndone), 32'd0);
      check({tag, "_held_err"}, 32'(err_count), 32'(e.err));
      check({tag, "_held_fail_vec"}, 32'(fail_vec), 32'(e.fv));
      check({tag, "_held_pass"}, 32'(pass), 32'(e.pass));
      check({tag, "_stim_hold"}, 32'({stim_b, stim_a}), 32'd3);
    end
  endtask

  initial begin
    int t0, ndone;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_fail_vec", 32'(fail_vec), 32'd0);
    check("rst_stim", 32'({stim_b, stim_a}), 32'd0);
    rst_n = 1'b1;

    run("xor_stuck0", 1, 3'd2, 7'h20, -1);
    run("not_inverted", 2, 3'd4, 7'h04, -1);
    run("good_bank", 0, 3'd0, 7'h00, -1);

    // Reset during vector idx=2 with a faulty bank so err/fail_vec are non-zero first.
    fault = 2;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t0 = cyc;
    repeat (7) @(negedge clk);
    check("mid_idx", 32'({stim_b, stim_a}), 32'd2);
    check("mid_err", 32'(err_count), 32'd2);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err", 32'(err_count), 32'd0);
    check("midrst_fail_vec", 32'(fail_vec), 32'd0);
    check("midrst_pass", 32'(pass), 32'd0);
    check("midrst_stim", 32'({stim_b, stim_a}), 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("midrst_no_done", 32'(ndone), 32'd0);

    run("after_reset", 0, 3'd0, 7'h00, -1);
    run("restart_ignored", 0, 3'd0, 7'h00, 3);

    // SETTLE_CYCLES=1 instance: each vector held 2 cycles, done after edge t0+8.
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("s1_stim_%0d", k), 32'({stim2_b, stim2_a}), 32'(k / 2));
      if (k == 7) check("s1_done_early", 32'(done2), 32'd0);
      @(negedge clk);
    end
    check("s1_done", 32'(done2), 32'd1);
    check("s1_pass", 32'(pass2), 32'd1);
    check("s1_err", 32'(err_count2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
